// File: rtl/uart_apb_regif_if.sv
// APB3 bus bundle between the interconnect (master) and the UART register front-end (slave).
interface uart_apb_regif_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/uart_apb_regif.sv
// APB3 register front-end for the UART core: CTRL/STATUS/TXDATA/RXDATA map, TX-full wait states, RX pop sequencing.
// Optional interrupt block (IRQ_EN/IRQ_STAT, irq output) is built only when UART_APB_IRQ_EN is defined.
module uart_apb_regif #(
    parameter int ADDR_WIDTH      = 5,
    parameter int TX_WAIT_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rstn,
    uart_apb_regif_if.slave     apb,
    output logic [5:0]          uart_ctrl_reg,
    output logic                uart_wren,
    output logic [7:0]          uart_tx_data,
    output logic                uart_rden,
    input  logic [7:0]          uart_rx_data,
    input  logic [7:0]          uart_status,
    output logic                irq
);

    localparam int CNT_REQ_W = $clog2(TX_WAIT_TIMEOUT + 1);
    localparam int CNT_W     = (CNT_REQ_W > 8) ? CNT_REQ_W : 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TX_WAIT_TIMEOUT);

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_TXDATA   = 3'd2;
    localparam logic [2:0] REG_RXDATA   = 3'd3;
    localparam logic [2:0] REG_IRQ_EN   = 3'd4;
    localparam logic [2:0] REG_IRQ_STAT = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_TX_WAIT = 3'd2,
        ST_RX_POP  = 3'd3,
        ST_RX_CAP  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [5:0]          ctrl_q, ctrl_d;
    logic [7:0]          rx_q, rx_d;

    logic [ADDR_WIDTH-1:0] paddr_s;
    logic [2:0]          reg_sel_s;
    logic                setup_s;
    logic                access_s;
    logic                tx_full_s;
    logic                rx_empty_s;
    logic [31:0]         prdata_s;
    logic                pready_s;
    logic                pslverr_s;
    logic                wren_s;
    logic                rden_s;
    logic                unused_s;

    assign paddr_s    = apb.paddr;
    assign reg_sel_s  = paddr_s[4:2];
    assign setup_s    = apb.psel & ~apb.penable;
    assign access_s   = apb.psel & apb.penable;
    assign tx_full_s  = uart_status[0];
    assign rx_empty_s = uart_status[4];
    assign unused_s   = ^{paddr_s[1:0], apb.pwdata[31:8]};

`ifdef UART_APB_IRQ_EN
    logic [1:0] irq_en_q, irq_en_d;
    logic [1:0] irq_stat_q, irq_stat_d;
    logic [1:0] irq_clr_s;
    logic [1:0] irq_set_s;
    logic       rx_empty_prev_q;
    logic       tx_empty_prev_q;
    logic       irq_q;
`endif

    // Bus response and next-state decode; responses follow the access-phase inputs in the same cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        rx_d      = rx_q;
        prdata_s  = 32'h0000_0000;
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        wren_s    = 1'b0;
        rden_s    = 1'b0;
`ifdef UART_APB_IRQ_EN
        irq_en_d  = irq_en_q;
        irq_clr_s = 2'b00;
`endif
        case (state_q)
            ST_IDLE: begin
                if (setup_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                if (access_s) begin
                    pready_s = 1'b1;
                    case (reg_sel_s)
                        REG_CTRL: begin
                            if (apb.pwrite) begin
                                ctrl_d = apb.pwdata[5:0];
                            end else begin
                                prdata_s = {26'h0, ctrl_q};
                            end
                        end
                        REG_STATUS: begin
                            if (apb.pwrite) begin
                                prdata_s = 32'h0000_0000;
                            end else begin
                                prdata_s = {24'h0, uart_status};
                            end
                        end
                        REG_TXDATA: begin
                            if (!apb.pwrite) begin
                                prdata_s = 32'h0000_0000;
                            end else if (!tx_full_s) begin
                                wren_s = 1'b1;
                            end else begin
                                pready_s = 1'b0;
                                cnt_d    = {CNT_W{1'b0}};
                                state_d  = ST_TX_WAIT;
                            end
                        end
                        REG_RXDATA: begin
                            if (apb.pwrite) begin
                                prdata_s = 32'h0000_0000;
                            end else if (rx_empty_s) begin
                                pslverr_s = 1'b1;
                            end else begin
                                pready_s = 1'b0;
                                rden_s   = 1'b1;
                                state_d  = ST_RX_POP;
                            end
                        end
`ifdef UART_APB_IRQ_EN
                        REG_IRQ_EN: begin
                            if (apb.pwrite) begin
                                irq_en_d = apb.pwdata[1:0];
                            end else begin
                                prdata_s = {30'h0, irq_en_q};
                            end
                        end
                        REG_IRQ_STAT: begin
                            if (apb.pwrite) begin
                                irq_clr_s = apb.pwdata[1:0];
                            end else begin
                                prdata_s = {30'h0, irq_stat_q};
                            end
                        end
`endif
                        default: begin
                            prdata_s = 32'h0000_0000;
                        end
                    endcase
                end else begin
                    pready_s = 1'b0;
                end
            end
            ST_TX_WAIT: begin
                if (!apb.psel) begin
                    state_d = ST_IDLE;
                end else if (!tx_full_s) begin
                    wren_s   = 1'b1;
                    pready_s = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    // Timed out: the byte is dropped and the master sees an error
                    pready_s  = 1'b1;
                    pslverr_s = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RX_POP: begin
                // FIFO output is valid the cycle after the pop; hold it for the response cycle
                rx_d = uart_rx_data;
                if (apb.psel) begin
                    state_d = ST_RX_CAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RX_CAP: begin
                state_d = ST_IDLE;
                if (apb.psel) begin
                    pready_s = 1'b1;
                    prdata_s = {24'h0, rx_q};
                end else begin
                    pready_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, wait counter, control register and captured RX byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            ctrl_q  <= 6'h00;
            rx_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            rx_q    <= rx_d;
        end
    end

`ifdef UART_APB_IRQ_EN
    assign irq_set_s  = {~tx_empty_prev_q & uart_status[1], rx_empty_prev_q & ~uart_status[4]};
    assign irq_stat_d = (irq_stat_q & ~irq_clr_s) | irq_set_s;

    // Interrupt edge detection, sticky status with set-over-clear, and registered irq level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_en_q        <= 2'b00;
            irq_stat_q      <= 2'b00;
            rx_empty_prev_q <= 1'b1;
            tx_empty_prev_q <= 1'b1;
            irq_q           <= 1'b0;
        end else begin
            irq_en_q        <= irq_en_d;
            irq_stat_q      <= irq_stat_d;
            rx_empty_prev_q <= uart_status[4];
            tx_empty_prev_q <= uart_status[1];
            irq_q           <= |(irq_stat_d & irq_en_d);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign apb.prdata   = prdata_s;
    assign apb.pready   = pready_s;
    assign apb.pslverr  = pslverr_s;
    assign uart_wren    = wren_s;
    assign uart_tx_data = wren_s ? apb.pwdata[7:0] : 8'h00;
    assign uart_rden    = rden_s;
    assign uart_ctrl_reg = ctrl_q;

endmodule

// File: tb/tb_uart_apb_regif.sv
// Randomized self-checking bench for uart_apb_regif; expected responses come from a transfer-level model of the register map.
module tb_uart_apb_regif;
    localparam int T = 6;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [5:0] ctrl;
    logic       wren, rden, irq;
    logic [7:0] txd, rxd, status;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [5:0] ctrl_m = 6'h00;

    always #5 clk = ~clk;

    uart_apb_regif_if #(.ADDR_WIDTH(5)) apb ();

    uart_apb_regif #(.ADDR_WIDTH(5), .TX_WAIT_TIMEOUT(T)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .apb           (apb),
        .uart_ctrl_reg (ctrl),
        .uart_wren     (wren),
        .uart_tx_data  (txd),
        .uart_rden     (rden),
        .uart_rx_data  (rxd),
        .uart_status   (status),
        .irq           (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One APB transfer; tx_full is held high for the first full_cycles cycles of the access phase
    task automatic apb_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                            input logic [7:0] st, input int full_cycles,
                            output logic [31:0] rdata, output logic err, output int waits,
                            output int wrens, output int rdens, output logic [7:0] txb);
        bit done = 1'b0;
        rdata = 32'h0; err = 1'b0; waits = 0; wrens = 0; rdens = 0; txb = 8'h00;
        @(posedge clk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = addr; apb.pwdata = wdata;
        @(negedge clk);
        check_eq("setup_pready", {31'h0, apb.pready}, 32'h0);
        if (wren) wrens++;
        if (rden) rdens++;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        for (int cyc = 0; cyc < 64; cyc++) begin
            status = {st[7:1], (cyc < full_cycles) ? 1'b1 : 1'b0};
            @(negedge clk);
            if (wren) begin wrens++; txb = txd; end
            if (rden) rdens++;
            if (apb.pready) begin
                rdata = apb.prdata; err = apb.pslverr; done = 1'b1;
                break;
            end
            waits++;
            @(posedge clk); #1;
        end
        if (!done) check_eq("pready_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0; status = {st[7:1], 1'b0};
        @(negedge clk);
        if (wren) wrens++;
        if (rden) rdens++;
    endtask

    // Run a transfer and compare it with the register-map rules
    task automatic run_one(input string tag, input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                           input logic [7:0] st, input int full, input logic [7:0] rx);
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          w, nw, nr, exp_w, exp_nw, exp_nr;
        logic [7:0]  tb, exp_tb;
        rxd = rx;
        apb_xfer(wr, addr, wdata, st, full, rd, er, w, nw, nr, tb);
        exp_rd = 32'h0; exp_er = 1'b0; exp_w = 0; exp_nw = 0; exp_nr = 0; exp_tb = 8'h00;
        case (addr[4:2])
            3'd0: if (wr) ctrl_m = wdata[5:0]; else exp_rd = {26'h0, ctrl_m};
            3'd1: if (!wr) exp_rd = {24'h0, st[7:1], (full > 0) ? 1'b1 : 1'b0};
            3'd2: if (wr) begin
                      if (full <= T + 1) begin exp_w = full; exp_nw = 1; exp_tb = wdata[7:0]; end
                      else begin exp_w = T + 1; exp_er = 1'b1; end
                  end
            3'd3: if (!wr) begin
                      if (st[4]) exp_er = 1'b1;
                      else begin exp_w = 2; exp_nr = 1; exp_rd = {24'h0, rx}; end
                  end
            default: exp_rd = 32'h0;
        endcase
        check_eq({tag, "_waits"}, w, exp_w);
        check_eq({tag, "_slverr"}, {31'h0, er}, {31'h0, exp_er});
        check_eq({tag, "_prdata"}, rd, exp_rd);
        check_eq({tag, "_wren_cnt"}, nw, exp_nw);
        check_eq({tag, "_rden_cnt"}, nr, exp_nr);
        if (exp_nw == 1) check_eq({tag, "_txbyte"}, {24'h0, tb}, {24'h0, exp_tb});
        check_eq({tag, "_ctrl"}, {26'h0, ctrl}, {26'h0, ctrl_m});
    endtask

    task automatic do_reset();
        rstn = 1'b0; apb.psel = 1'b0; apb.penable = 1'b0; status = 8'h12;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        ctrl_m = 6'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w, nw, nr, full;
        logic [7:0]  tb, st;
        logic [2:0]  sel;
        logic        wr;

        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 5'h00; apb.pwdata = 32'h0;
        status = 8'h12; rxd = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_pready", {31'h0, apb.pready}, 32'h0);
        check_eq("rst_pslverr", {31'h0, apb.pslverr}, 32'h0);
        check_eq("rst_prdata", apb.prdata, 32'h0);
        check_eq("rst_strobes", {30'h0, wren, rden}, 32'h0);
        check_eq("rst_txdata", {24'h0, txd}, 32'h0);
        check_eq("rst_ctrl", {26'h0, ctrl}, 32'h0);
        check_eq("rst_irq", {31'h0, irq}, 32'h0);
        @(posedge clk); #1 rstn = 1'b1;

        run_one("rd_ctrl0", 1'b0, 5'h00, 32'h0, 8'h12, 0, 8'h00);
        run_one("rd_status", 1'b0, 5'h04, 32'h0, 8'h12, 0, 8'h00);
        run_one("wr_ctrl3d", 1'b1, 5'h00, 32'h0000_003D, 8'h12, 0, 8'h00);
        run_one("rd_ctrl3d", 1'b0, 5'h00, 32'h0, 8'h12, 0, 8'h00);
        run_one("wr_ctrl_hi", 1'b1, 5'h00, 32'hFFFF_FFC0, 8'h12, 0, 8'h00);
        run_one("tx_a5", 1'b1, 5'h08, 32'h0000_00A5, 8'h12, 0, 8'h00);
        run_one("tx_wait3", 1'b1, 5'h08, 32'h0000_0042, 8'h12, 3, 8'h00);
        run_one("tx_edge", 1'b1, 5'h08, 32'h0000_0011, 8'h12, T + 1, 8'h00);
        run_one("tx_tmo", 1'b1, 5'h08, 32'h0000_0033, 8'h12, T + 2, 8'h00);
        run_one("rx_5c", 1'b0, 5'h0C, 32'h0, 8'h02, 0, 8'h5C);
        run_one("rx_empty", 1'b0, 5'h0C, 32'h0, 8'h12, 0, 8'h77);
        run_one("rd_other", 1'b0, 5'h1C, 32'h0, 8'h12, 0, 8'h00);

        for (int i = 0; i < 60; i++) begin
            sel = 3'($urandom_range(0, 7));
`ifdef UART_APB_IRQ_EN
            if (sel == 3'd4 || sel == 3'd5) sel = 3'd6;
`endif
            wr   = 1'($urandom_range(0, 1));
            st   = 8'($urandom);
            full = (sel == 3'd2 && wr) ? $urandom_range(0, T + 2) : $urandom_range(0, 1);
            run_one("rand", wr, {sel, 2'($urandom)}, $urandom, st, full, 8'($urandom));
        end

`ifdef UART_APB_IRQ_EN
        do_reset();
        apb_xfer(1'b1, 5'h10, 32'h1, 8'h12, 0, rd, er, w, nw, nr, tb);
        check_eq("irq_idle", {31'h0, irq}, 32'h0);
        @(posedge clk); #1 status = 8'h02;
        repeat (2) @(negedge clk);
        check_eq("irq_rx_edge", {31'h0, irq}, 32'h1);
        apb_xfer(1'b0, 5'h14, 32'h0, 8'h02, 0, rd, er, w, nw, nr, tb);
        check_eq("irq_stat_rd", rd, 32'h1);
        apb_xfer(1'b1, 5'h14, 32'h1, 8'h02, 0, rd, er, w, nw, nr, tb);
        check_eq("irq_w1c", {31'h0, irq}, 32'h0);
        @(posedge clk); #1 status = 8'h12;
        repeat (2) @(negedge clk);
        apb_xfer(1'b1, 5'h14, 32'h1, 8'h02, 0, rd, er, w, nw, nr, tb);
        check_eq("irq_set_wins", {31'h0, irq}, 32'h1);
`else
        check_eq("irq_tied", {31'h0, irq}, 32'h0);
`endif

        // Master drops psel while the TXDATA write is waiting
        @(posedge clk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 5'h08; apb.pwdata = 32'h99;
        @(posedge clk); #1 apb.penable = 1'b1; status = 8'h13;
        @(negedge clk);
        check_eq("drop_wait", {31'h0, apb.pready}, 32'h0);
        @(posedge clk); #1 apb.psel = 1'b0; apb.penable = 1'b0; status = 8'h12;
        @(negedge clk);
        check_eq("drop_no_wren", {30'h0, wren, apb.pready}, 32'h0);
        @(negedge clk);
        check_eq("drop_no_wren2", {31'h0, wren}, 32'h0);

        // Reset asserted during the TX wait
        run_one("pre_rst_ctrl", 1'b1, 5'h00, 32'h15, 8'h12, 0, 8'h00);
        @(posedge clk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 5'h08; apb.pwdata = 32'h77;
        @(posedge clk); #1 apb.penable = 1'b1; status = 8'h13;
        @(posedge clk); #1;
        @(posedge clk); #1;
        status = 8'h12; rstn = 1'b0;
        #1;
        check_eq("mid_rst_pready", {30'h0, apb.pready, apb.pslverr}, 32'h0);
        check_eq("mid_rst_wren", {31'h0, wren}, 32'h0);
        check_eq("mid_rst_irq", {31'h0, irq}, 32'h0);
        check_eq("mid_rst_ctrl", {26'h0, ctrl}, 32'h0);
        apb.psel = 1'b0; apb.penable = 1'b0;
        @(posedge clk); #1 rstn = 1'b1; ctrl_m = 6'h00;
        @(negedge clk);
        check_eq("post_rst_no_wren", {31'h0, wren}, 32'h0);
        run_one("post_rst_tx", 1'b1, 5'h08, 32'h3C, 8'h12, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
